// File: rtl/mem_responder_pkg.sv
// Shared constants for the CPU memory request bus: FSM encoding, default widths
// and the byte-to-word index shift.
package mem_bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-to-memory request/response bundle; the CPU drives the master side and the
// responder sits on the slave side.
interface mem_responder_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata, err, busy
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Word storage for the responder: one synchronous write port, one combinational
// read port, contents deliberately left unreset.
module mem_array #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side target of the CPU request bus: accepts one request, waits
// WAIT_CYCLES, then commits/reads and pulses ready for one cycle.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                DEPTH       = 64,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_responder_if.slave  bus
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = $clog2(DEPTH);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              ready_r;
  logic              err_r;
  logic [DATA_W-1:0] rdata_r;

  logic              accept;
  logic              enter_resp;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [ADDR_W-1:0] off;
  logic              misaligned;
  logic              out_of_range;
  logic              access_err;
  logic [IDX_W-1:0]  idx;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign accept     = (state == ST_IDLE) && bus.req;
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == ST_WAIT) && (cnt == CNT_W'(1)));

  // With zero wait states the response is formed on the accepting edge, so the
  // live bus fields stand in for the not-yet-latched copies.
  assign cur_we    = (state == ST_IDLE) ? bus.we    : lat_we;
  assign cur_addr  = (state == ST_IDLE) ? bus.addr  : lat_addr;
  assign cur_wdata = (state == ST_IDLE) ? bus.wdata : lat_wdata;

  assign off          = cur_addr - BASE_ADDR;
  assign misaligned   = |cur_addr[WORD_SHIFT-1:0];
  assign out_of_range = (cur_addr < BASE_ADDR) ||
                        ((off >> WORD_SHIFT) >= ADDR_W'(DEPTH));
  assign access_err   = misaligned || out_of_range;
  assign idx          = off[IDX_W+WORD_SHIFT-1:WORD_SHIFT];
  assign mem_we       = enter_resp && cur_we && !access_err;

  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_idx  (idx),
    .wr_data (cur_wdata),
    .rd_idx  (idx),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ready_r   <= 1'b0;
      err_r     <= 1'b0;
      rdata_r   <= '0;
    end else begin
      ready_r <= enter_resp;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            lat_we    <= bus.we;
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            cnt       <= CNT_W'(WAIT_CYCLES);
            state     <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      // rdata/err persist after the pulse until the next response overwrites them.
      if (enter_resp) begin
        err_r   <= access_err;
        rdata_r <= access_err ? '0 : (cur_we ? cur_wdata : mem_rdata);
      end
    end
  end

  assign bus.ready = ready_r;
  assign bus.err   = err_r;
  assign bus.rdata = rdata_r;
  assign bus.busy  = (state != ST_IDLE);

endmodule
